// File: rtl/tt_encoder_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_encoder_serializer_pkg
//  Description : Shared helpers for the round-robin encoder/serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_encoder_serializer_pkg;

   // Round-robin successor of a selected index; wraps explicitly so that
   // widths which are not a power of two behave correctly.
   function automatic int unsigned rr_next_ptr(input int unsigned sel,
                                               input int unsigned width);
      return (sel == width - 1) ? 0 : sel + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tt_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tt_decoder
//  Description : Binary-to-one-hot decoder with enable; all-zero when disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_decoder #(
   parameter int DECODED_WIDTH = 8,
   parameter int ENCODED_WIDTH = $clog2(DECODED_WIDTH)
) (
   input  logic                     i_enable,
   input  logic [ENCODED_WIDTH-1:0] i_encoded_signal,
   output logic [DECODED_WIDTH-1:0] o_decoded_signal
);

   // One output bit per index, gated by the enable.
   always_comb begin
      o_decoded_signal = '0;
      for (int i = 0; i < DECODED_WIDTH; i++) begin
         o_decoded_signal[i] = i_enable && (i_encoded_signal == ENCODED_WIDTH'(i));
      end
   end

endmodule
`default_nettype wire

// File: rtl/tt_encoder_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tt_encoder_serializer
//  Description : Drains a multi-hot request vector as a stream of binary
//                indices, one set bit per beat, in round-robin order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_encoder_serializer
   import tt_encoder_serializer_pkg::*;
#(
   parameter int REQ_WIDTH          = 32,
   parameter int ENCODED_WIDTH      = $clog2(REQ_WIDTH),
   parameter bit DISABLE_ASSERTIONS = 1'b0
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [REQ_WIDTH-1:0]     i_req,
   input  logic                     i_flush,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [ENCODED_WIDTH-1:0] o_encoded,
   output logic [REQ_WIDTH-1:0]     o_onehot,
   output logic                     o_last
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic [REQ_WIDTH-1:0] ONE = REQ_WIDTH'(1);

   state_t                   state, state_next;
   logic [REQ_WIDTH-1:0]     pending, pending_next;
   logic [ENCODED_WIDTH-1:0] ptr, ptr_next;
   logic [ENCODED_WIDTH-1:0] sel, sel_masked, sel_any;
   logic                     found_masked, found_any;
   logic                     last_bit;
   logic                     beat, load;

   // Round-robin pick: lowest set bit at or above ptr, else lowest set bit.
   always_comb begin
      found_masked = 1'b0;
      found_any    = 1'b0;
      sel_masked   = '0;
      sel_any      = '0;
      for (int i = 0; i < REQ_WIDTH; i++) begin
         if (pending[i] && !found_any) begin
            found_any = 1'b1;
            sel_any   = i[ENCODED_WIDTH-1:0];
         end
         if (pending[i] && (i >= int'(ptr)) && !found_masked) begin
            found_masked = 1'b1;
            sel_masked   = i[ENCODED_WIDTH-1:0];
         end
      end
      sel      = found_masked ? sel_masked : sel_any;
      last_bit = (pending != '0) && ((pending & (pending - ONE)) == '0);
   end

   // Output handshake; flush masks both sides for the current cycle.
   always_comb begin
      o_valid   = (state == DRAIN) && !i_flush;
      o_encoded = o_valid ? sel : '0;
      o_last    = o_valid && last_bit;
      o_ready   = !i_flush && ((state == IDLE) || (o_valid && i_ready && o_last));
   end

   tt_decoder #(
      .DECODED_WIDTH (REQ_WIDTH),
      .ENCODED_WIDTH (ENCODED_WIDTH)
   ) u_decoder (
      .i_enable         (o_valid),
      .i_encoded_signal (o_encoded),
      .o_decoded_signal (o_onehot)
   );

   assign beat = o_valid && i_ready;
   assign load = i_valid && o_ready;

   // Next state: beat first, a coinciding load overrides, flush overrides all.
   always_comb begin
      state_next   = state;
      pending_next = pending;
      ptr_next     = ptr;
      if (beat) begin
         pending_next = pending & ~o_onehot;
         ptr_next     = ENCODED_WIDTH'(rr_next_ptr(32'(sel), REQ_WIDTH));
         if (o_last) begin
            state_next = IDLE;
         end
      end
      if (load) begin
         pending_next = i_req;
         state_next   = (i_req != '0) ? DRAIN : IDLE;
      end
      if (i_flush) begin
         pending_next = '0;
         state_next   = IDLE;
      end
   end

   // State registers; ptr is retained across vectors and flushes.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state   <= IDLE;
         pending <= '0;
         ptr     <= '0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         ptr     <= ptr_next;
      end
   end

   generate
      if (DISABLE_ASSERTIONS == 1'b0) begin : g_assertions
         a_valid_onehot : assert property (@(posedge i_clk) disable iff (!i_reset_n)
            o_valid |-> ($onehot(o_onehot) && (int'(o_encoded) < REQ_WIDTH)));
         a_idle_zero : assert property (@(posedge i_clk) disable iff (!i_reset_n)
            !o_valid |-> (o_onehot == '0));
         a_pending_state : assert property (@(posedge i_clk) disable iff (!i_reset_n)
            ((pending != '0) == (state == DRAIN)));
      end
   endgenerate

endmodule
`default_nettype wire
